otbn_load_wb: RTL and testbench

//  Load-return/writeback stage sitting directly downstream of the OTBN load-store unit.
//  - Tracks every issued DMEM load.
//  - Captures the returned 32b (base) or WLEN (bignum) read data one cycle after the request.
//  - Drives a single-cycle registered write into the GPR or WDR register file.
//  - Checks the DMEM response protocol (missing, unexpected or erroneous rvalid) and locks
//    up on the first violation.
//

---
 rtl/otbn_load_wb.sv | 148 ++++++++++++++
 tb/tb_otbn_load_wb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otbn_load_wb.sv
// OTBN load-return / writeback stage.
// Tracks DMEM loads, writes GPR/WDR, locks on response protocol errors.
module otbn_load_wb #(
  parameter int BaseIntgWidth = 39,
  parameter int ExtWLEN       = 312,
  parameter int RegAddrW      = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_req_i,
  input  logic                     load_subset_i,
  input  logic [RegAddrW-1:0]      load_rd_i,
  input  logic                     dmem_rvalid_i,
  input  logic [BaseIntgWidth-1:0] lsu_base_rdata_i,
  input  logic [ExtWLEN-1:0]       lsu_bignum_rdata_i,
  input  logic                     lsu_rdata_err_i,
  output logic                     gpr_wr_en_o,
  output logic [RegAddrW-1:0]      gpr_wr_addr_o,
  output logic [BaseIntgWidth-1:0] gpr_wr_data_o,
  output logic                     wdr_wr_en_o,
  output logic [RegAddrW-1:0]      wdr_wr_addr_o,
  output logic [ExtWLEN-1:0]       wdr_wr_data_o,
  output logic                     load_busy_o,
  output logic                     err_o,
  output logic [2:0]               err_cause_o
);

  typedef enum logic {
    StRun,
    StLocked
  } state_e;

  state_e state_q, state_d;

  logic                pend_q, pend_d;
  logic                sub_q, sub_d;
  logic [RegAddrW-1:0] rd_q, rd_d;

  logic                gpr_en_q, gpr_en_d;
  logic                wdr_en_q, wdr_en_d;
  logic [RegAddrW-1:0] gpr_addr_q, wdr_addr_q;
  logic [BaseIntgWidth-1:0] gpr_data_q;
  logic [ExtWLEN-1:0]  wdr_data_q;

  logic                err_q, err_d;
  logic [2:0]          cause_q, cause_d;
  logic [2:0]          viol;

  // Violation terms: {unexpected_rsp, no_rsp, rdata_err}
  always_comb begin
    viol = 3'b000;
    viol[2] = ~pend_q & dmem_rvalid_i;
    viol[1] = pend_q & ~dmem_rvalid_i;
    viol[0] = pend_q & dmem_rvalid_i & lsu_rdata_err_i;
  end

  // Next-state, pending-entry and writeback-strobe decisions
  always_comb begin
    state_d  = state_q;
    pend_d   = 1'b0;
    sub_d    = sub_q;
    rd_d     = rd_q;
    gpr_en_d = 1'b0;
    wdr_en_d = 1'b0;
    err_d    = err_q;
    cause_d  = cause_q;
    unique case (state_q)
      StRun: begin
        pend_d = load_req_i;
        if (load_req_i) begin
          sub_d = load_subset_i;
          rd_d  = load_rd_i;
        end
        cause_d = cause_q | viol;
        if (|viol) begin
          err_d   = 1'b1;
          state_d = StLocked;
        end
        if (pend_q && dmem_rvalid_i && !lsu_rdata_err_i) begin
          if (sub_q) begin
            wdr_en_d = 1'b1;
          end else if (rd_q != '0) begin
            gpr_en_d = 1'b1;
          end
        end
      end
      StLocked: begin
        state_d = StLocked;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StRun;
      pend_q   <= 1'b0;
      sub_q    <= 1'b0;
      rd_q     <= '0;
      gpr_en_q <= 1'b0;
      wdr_en_q <= 1'b0;
      err_q    <= 1'b0;
      cause_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      sub_q    <= sub_d;
      rd_q     <= rd_d;
      gpr_en_q <= gpr_en_d;
      wdr_en_q <= wdr_en_d;
      err_q    <= err_d;
      cause_q  <= cause_d;
    end
  end

  // Writeback payload, captured only when a strobe is issued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpr_addr_q <= '0;
      gpr_data_q <= '0;
      wdr_addr_q <= '0;
      wdr_data_q <= '0;
    end else begin
      if (gpr_en_d) begin
        gpr_addr_q <= rd_q;
        gpr_data_q <= lsu_base_rdata_i;
      end
      if (wdr_en_d) begin
        wdr_addr_q <= rd_q;
        wdr_data_q <= lsu_bignum_rdata_i;
      end
    end
  end

  assign gpr_wr_en_o   = gpr_en_q;
  assign gpr_wr_addr_o = gpr_addr_q;
  assign gpr_wr_data_o = gpr_data_q;
  assign wdr_wr_en_o   = wdr_en_q;
  assign wdr_wr_addr_o = wdr_addr_q;
  assign wdr_wr_data_o = wdr_data_q;
  assign load_busy_o   = pend_q | gpr_en_q | wdr_en_q;
  assign err_o         = err_q;
  assign err_cause_o   = cause_q;

endmodule

// File: tb/tb_otbn_load_wb.sv
// Directed bench for otbn_load_wb.
// Expected writes go to a scoreboard queue, popped by a strobe monitor.
module tb_otbn_load_wb;

  localparam int BW = 39;
  localparam int EW = 312;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          load_subset = 1'b0;
  logic [AW-1:0] load_rd = '0;
  logic          rvalid = 1'b0;
  logic [BW-1:0] base_rdata = '0;
  logic [EW-1:0] big_rdata = '0;
  logic          rdata_err = 1'b0;

  logic          gpr_wr_en;
  logic [AW-1:0] gpr_wr_addr;
  logic [BW-1:0] gpr_wr_data;
  logic          wdr_wr_en;
  logic [AW-1:0] wdr_wr_addr;
  logic [EW-1:0] wdr_wr_data;
  logic          load_busy;
  logic          err;
  logic [2:0]    err_cause;

  otbn_load_wb dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .load_req_i         (load_req),
    .load_subset_i      (load_subset),
    .load_rd_i          (load_rd),
    .dmem_rvalid_i      (rvalid),
    .lsu_base_rdata_i   (base_rdata),
    .lsu_bignum_rdata_i (big_rdata),
    .lsu_rdata_err_i    (rdata_err),
    .gpr_wr_en_o        (gpr_wr_en),
    .gpr_wr_addr_o      (gpr_wr_addr),
    .gpr_wr_data_o      (gpr_wr_data),
    .wdr_wr_en_o        (wdr_wr_en),
    .wdr_wr_addr_o      (wdr_wr_addr),
    .wdr_wr_data_o      (wdr_wr_data),
    .load_busy_o        (load_busy),
    .err_o              (err),
    .err_cause_o        (err_cause)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wdr;
    logic [AW-1:0] addr;
    logic [EW-1:0] data;
    int            at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [EW-1:0] obs,
                     input logic [EW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (gpr_wr_en || wdr_wr_en) begin
      if (sb.size() == 0) begin
        chk("stray_wr", {gpr_wr_en, wdr_wr_en}, '0);
      end else begin
        e = sb.pop_front();
        chk("wr_port", wdr_wr_en, e.wdr);
        chk("wr_cyc", cyc, e.at);
        if (e.wdr) begin
          chk("wdr_addr", wdr_wr_addr, e.addr);
          chk("wdr_data", wdr_wr_data, e.data);
        end else begin
          chk("gpr_addr", gpr_wr_addr, e.addr);
          chk("gpr_data", gpr_wr_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_req  = 1'b0;
    rvalid    = 1'b0;
    rdata_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a,
                      input logic [EW-1:0] d, input int at);
    exp_t e;
    e.wdr  = w;
    e.addr = a;
    e.data = d;
    e.at   = at;
    sb.push_back(e);
  endtask

  function automatic logic [EW-1:0] big(input logic [31:0] s);
    return {s[23:0], {9{s}}};
  endfunction

  logic [EW-1:0] b3, b4;

  initial begin
    b3 = big(32'hA5A5_0303);
    b4 = big(32'h5A5A_0404);

    // Reset state
    tick();
    chk("rst_gpr_en", gpr_wr_en, '0);
    chk("rst_wdr_en", wdr_wr_en, '0);
    chk("rst_gpr_data", gpr_wr_data, '0);
    chk("rst_wdr_data", wdr_wr_data, '0);
    chk("rst_busy", load_busy, '0);
    chk("rst_err", err, '0);
    chk("rst_cause", err_cause, '0);
    rst = 1'b0;
    tick();

    // 1. Base load to rd 7
    load_req = 1'b1; load_subset = 1'b0; load_rd = 5'd7;
    push(1'b0, 5'd7, EW'(39'h12_3456789A), cyc + 2);
    tick();
    chk("t1_busy_n1", load_busy, 1);
    load_req = 1'b0; rvalid = 1'b1; base_rdata = 39'h12_3456789A;
    tick();
    chk("t1_busy_n2", load_busy, 1);
    idle();
    tick();
    chk("t1_busy_n3", load_busy, 0);
    chk("t1_err", err, 0);

    // 2. Back-to-back bignum loads to rd 3 and rd 4
    load_req = 1'b1; load_subset = 1'b1; load_rd = 5'd3;
    push(1'b1, 5'd3, b3, cyc + 2);
    tick();
    load_rd = 5'd4; rvalid = 1'b1; big_rdata = b3;
    push(1'b1, 5'd4, b4, cyc + 2);
    tick();
    load_req = 1'b0; big_rdata = b4;
    tick();
    idle();
    tick();
    tick();
    chk("t2_err", err, 0);
    chk("t2_cause", err_cause, 3'b000);
    chk("t2_busy", load_busy, 0);

    // 3. Missing response locks; later loads are ignored
    load_req = 1'b1; load_subset = 1'b0; load_rd = 5'd9;
    tick();
    idle();
    tick();
    chk("t3_err", err, 1);
    chk("t3_cause", err_cause, 3'b010);
    tick();
    tick();
    load_req = 1'b1; load_rd = 5'd10; base_rdata = 39'h7F_00000001;
    tick();
    load_req = 1'b0; rvalid = 1'b1;
    tick();
    idle();
    chk("t3_lock_busy", load_busy, 0);
    tick();
    chk("t3_lock_gpr", gpr_wr_en, 0);
    chk("t3_cause_hold", err_cause, 3'b010);
    do_reset();
    chk("t3_rst_err", err, 0);

    // 4. Read error: no write, cause rdata_err
    load_req = 1'b1; load_subset = 1'b0; load_rd = 5'd5;
    tick();
    load_req = 1'b0; rvalid = 1'b1; rdata_err = 1'b1;
    base_rdata = 39'h01_DEADBEEF;
    tick();
    idle();
    chk("t4_err", err, 1);
    chk("t4_cause", err_cause, 3'b001);
    tick();
    chk("t4_no_wr", gpr_wr_en, 0);
    do_reset();

    // 5a. Stray response
    rvalid = 1'b1;
    tick();
    idle();
    chk("t5_cause", err_cause, 3'b100);
    chk("t5_err", err, 1);
    do_reset();

    // 5b. Base load to rd 0 is silently dropped
    load_req = 1'b1; load_subset = 1'b0; load_rd = 5'd0;
    tick();
    load_req = 1'b0; rvalid = 1'b1; base_rdata = 39'h55_55555555;
    tick();
    idle();
    tick();
    chk("t5_rd0_err", err, 0);
    chk("t5_rd0_gpr", gpr_wr_en, 0);

    // 6. Reset mid-load drops the write; fresh load then completes
    load_req = 1'b1; load_subset = 1'b0; load_rd = 5'd11;
    tick();
    load_req = 1'b0; rvalid = 1'b1; base_rdata = 39'h33_CAFEF00D;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", load_busy, 0);
    chk("t6_rst_gpr", gpr_wr_en, 0);
    chk("t6_rst_data", gpr_wr_data, '0);
    chk("t6_rst_err", err, 0);
    tick();
    chk("t6_no_wr", gpr_wr_en, 0);
    idle();
    rst = 1'b0;
    tick();
    load_req = 1'b1; load_rd = 5'd12;
    push(1'b0, 5'd12, EW'(39'h44_01234567), cyc + 2);
    tick();
    load_req = 1'b0; rvalid = 1'b1; base_rdata = 39'h44_01234567;
    tick();
    idle();
    tick();
    tick();
    chk("t6_err", err, 0);

    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
